pcm_sched: RTL and testbench
============================

Name: pcm_sched

Overview:
- Sample scheduler and feeder for the SDM input stage (pipe_pcm), which runs on 16-cycle slots with 64 slots per PCM sample.
- Buffers stereo PCM pairs from the upstream source in a small FIFO and primes it before asserting start.
- Presents one L/R pair per 1024-pclk period, changing the value only between the datapath's slot-63 and slot-0 sampling instants.
- Handles underrun by muting. After repeated underruns it drops start so the SDM re-primes cleanly.

Parameters:
DEPTH, 8, FIFO entries (stereo pairs); power of 2.
PRIME_LVL, 4, fill level needed to leave PRIME; range 1..DEPTH.
LOAD_PHASE, 1016, period-counter value at which the next pair is loaded; range 1009..1023.
UR_LIMIT, 16, consecutive empty loads before re-prime; 0 disables re-prime.

Ports:
pclk  in  1  45.1584 MHz clock
reset_n  in  1  asynchronous active-low reset
enable  in  1  run request
in_valid  in  1  upstream pair valid
in_ready  out  1  FIFO can accept
in_left  in  32  signed PCM left
in_right  in  32  signed PCM right
start  out  1  to pipe_pcm start (both channel instances)
pcm_l  out  32  to left pipe_pcm pcm
pcm_r  out  32  to right pipe_pcm pcm
sdm_started  in  1  AND of both pipe_pcm started outputs
running  out  1  RUN and sdm_started
underrun  out  1  sticky underrun flag
ur_clr  in  1  clears underrun
fill  out  $clog2(DEPTH+1)  FIFO occupancy

Behaviour:
- Reset is asynchronous, active-low reset_n on clock pclk. Reset values: start 0, pcm_l/pcm_r 0, in_ready 0, underrun 0, fill 0, running 0, state IDLE, period counter cnt 1023.
- All outputs are registered except running, which is RUN and sdm_started.
- Push occurs when in_valid and in_ready. in_ready = (state != IDLE) and (fill < DEPTH); there is no bypass.
- Simultaneous push and pop leaves fill unchanged.

States:
- IDLE: entered on reset or when enable=0. FIFO flushed, pcm 0, start 0, cnt 1023. Goes to PRIME when enable=1.
- PRIME: accepts pushes; start 0. When fill >= PRIME_LVL, goes to RUN on that edge. On the same edge: start becomes 1, the FIFO head is popped into pcm_l/pcm_r, and cnt is held at 1023.
- RUN: start 1. cnt increments every cycle and wraps 1023 to 0.
  - The first RUN cycle has cnt=1023, so cnt=0 coincides with the datapath's first i==0 cycle. The datapath samples pcm at cnt%16==0.
  - At the edge ending cnt==LOAD_PHASE, the FIFO head is popped into pcm, or pcm is set to 0 if the FIFO is empty.
  - Sample period is exactly 1024 pclk. Each pair is sampled 64 times.
- Underrun: an empty load sets underrun and increments ur_run. A non-empty load clears ur_run.
  - When ur_run reaches UR_LIMIT (UR_LIMIT != 0), next state is PRIME: start 0 and pcm 0 on that edge, cnt 1023, FIFO kept.
- enable=0 in any state: next edge goes to IDLE, start 0, FIFO flushed, pcm 0.
- underrun is cleared only by ur_clr or reset. If a set and ur_clr occur in the same cycle, set wins.
- Reset mid-run: immediate return to reset values. The datapath resets through start=0.

Decomposition:
- Package pcm_sched_pkg holds: SLOT_LEN=16, SLOTS_PER_SAMPLE=64, PERIOD=1024, and the state enum {IDLE, PRIME, RUN}.
- One sub-module, pcm_sched_fifo: a synchronous FIFO of DEPTH×64 bits with push/pop/flush and a fill output.

Test Plan:
- Defaults, enable=1, push pairs (1,-1)..(4,-4) back-to-back: start rises the cycle after fill hits 4 (call it T); pcm_l=1, pcm_r=-1 from T; pcm changes to (2,-2) at T+1018, then every 1024 cycles.
- RUN with continuous in_valid: fill saturates at 8 and in_ready=0. After each load pop, in_ready=1 for one cycle and fill returns to 8.
- After 2 pairs in RUN, stop feeding: the third load gives pcm=0 and underrun=1. At the 16th empty load, start=0 next cycle, state PRIME, running=0. Re-feeding 4 pairs restarts with the same timing as scenario 1.
- enable 1→0 mid-period: next cycle start=0, in_ready=0, fill=0, pcm=0, underrun unchanged. Pulsing ur_clr clears it; ur_clr coinciding with an empty load leaves underrun=1.
- Assert reset_n low mid-cycle during RUN: start, pcm, fill, underrun and in_ready go to 0 before the next pclk edge.
- Model sdm_started rising at T+1+62*16+8: running stays 0 until sdm_started=1, then equals 1 while in RUN.

Source files
------------

// File: rtl/pcm_sched_pkg.sv
// Shared timing constants, FSM states and the stereo pair layout for the SDM sample feeder.
package pcm_sched_pkg;

    localparam int SLOT_LEN         = 16;
    localparam int SLOTS_PER_SAMPLE = 64;
    localparam int PERIOD           = SLOT_LEN * SLOTS_PER_SAMPLE;
    localparam int CNT_W            = $clog2(PERIOD);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        RUN
    } state_t;

    typedef struct packed {
        logic [31:0] left;
        logic [31:0] right;
    } pair_t;

endpackage

// File: rtl/pcm_sched_fifo.sv
// Synchronous FIFO of stereo pairs; pop data is the current head, valid the same cycle.
// Push is ignored when full and pop when empty; flush wins over both.
module pcm_sched_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 64
) (
    input  logic                       pclk,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_dat,
    input  logic                       pop,
    input  logic                       flush,
    output logic [WIDTH-1:0]           head_dat,
    output logic [$clog2(DEPTH+1)-1:0] fill
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int FW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok  = push && (fill != FW'(DEPTH));
    assign pop_ok   = pop && (fill != '0);
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge pclk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            fill <= fill + FW'(push_ok) - FW'(pop_ok);
        end
    end

endmodule

// File: rtl/pcm_sched.sv
// Primes a pair FIFO, then feeds one L/R pair per 1024-pclk period to the SDM; mutes on underrun.
// Loads land at LOAD_PHASE, between the slot-63 and slot-0 sampling instants; in_ready drops at DEPTH.
module pcm_sched
    import pcm_sched_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int PRIME_LVL  = 4,
    parameter int LOAD_PHASE = 1016,
    parameter int UR_LIMIT   = 16
) (
    input  logic                       pclk,
    input  logic                       reset_n,
    input  logic                       enable,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_left,
    input  logic [31:0]                in_right,
    output logic                       start,
    output logic [31:0]                pcm_l,
    output logic [31:0]                pcm_r,
    input  logic                       sdm_started,
    output logic                       running,
    output logic                       underrun,
    input  logic                       ur_clr,
    output logic [$clog2(DEPTH+1)-1:0] fill
);

    localparam int FW  = $clog2(DEPTH + 1);
    localparam int URW = $clog2(UR_LIMIT + 2);
    localparam logic [CNT_W-1:0] LOAD_CNT = CNT_W'(LOAD_PHASE);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_d;
    logic [URW-1:0]   ur_run;
    logic [URW-1:0]   ur_run_d;
    logic [URW-1:0]   ur_run_inc;
    pair_t            head;
    pair_t            pcm_d;
    logic             start_d;
    logic             in_ready_d;
    logic             underrun_d;
    logic             push;
    logic             pop;
    logic             flush;
    logic             load;
    logic             fifo_empty;
    logic             prime_done;
    logic             ur_hit;
    logic [FW-1:0]    fill_d;

    assign push       = in_valid && in_ready;
    assign fifo_empty = (fill == '0);
    assign load       = enable && (state_q == RUN) && (cnt == LOAD_CNT);
    assign prime_done = (state_q == PRIME) && (fill >= FW'(PRIME_LVL));
    assign ur_run_inc = ur_run + URW'(1);
    assign ur_hit     = (UR_LIMIT != 0) && load && fifo_empty && (ur_run_inc == URW'(UR_LIMIT));
    assign running    = (state_q == RUN) && sdm_started;

    pcm_sched_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (64)
    ) u_fifo (
        .pclk     (pclk),
        .reset_n  (reset_n),
        .push     (push),
        .push_dat ({in_left, in_right}),
        .pop      (pop),
        .flush    (flush),
        .head_dat (head),
        .fill     (fill)
    );

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = PRIME;
                PRIME:   if (prime_done) state_d = RUN;
                RUN:     if (ur_hit) state_d = PRIME;
                default: state_d = IDLE;
            endcase
        end
    end

    // Next values of the registered outputs, keyed on the transition being taken.
    always_comb begin
        pop      = 1'b0;
        flush    = 1'b0;
        start_d  = start;
        pcm_d    = {pcm_l, pcm_r};
        cnt_d    = CNT_LAST;
        ur_run_d = '0;
        if (state_d == IDLE) begin
            flush   = 1'b1;
            start_d = 1'b0;
            pcm_d   = '0;
        end else if (state_d == PRIME) begin
            start_d = 1'b0;
            if (state_q == RUN) pcm_d = '0;
        end else if (state_q == PRIME) begin
            // Counter held at the last phase so cnt=0 lines up with the datapath's first slot.
            pop     = 1'b1;
            start_d = 1'b1;
            pcm_d   = head;
        end else begin
            cnt_d    = cnt + CNT_W'(1);
            ur_run_d = ur_run;
            if (load) begin
                if (fifo_empty) begin
                    pcm_d    = '0;
                    ur_run_d = ur_run_inc;
                end else begin
                    pop      = 1'b1;
                    pcm_d    = head;
                    ur_run_d = '0;
                end
            end
        end

        fill_d     = flush ? '0 : fill + FW'(push) - FW'(pop);
        in_ready_d = (state_d != IDLE) && (fill_d < FW'(DEPTH));

        underrun_d = underrun;
        if (load && fifo_empty) underrun_d = 1'b1;
        else if (ur_clr)        underrun_d = 1'b0;
    end

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            cnt      <= CNT_LAST;
            ur_run   <= '0;
            start    <= 1'b0;
            pcm_l    <= '0;
            pcm_r    <= '0;
            in_ready <= 1'b0;
            underrun <= 1'b0;
        end else begin
            cnt      <= cnt_d;
            ur_run   <= ur_run_d;
            start    <= start_d;
            pcm_l    <= pcm_d.left;
            pcm_r    <= pcm_d.right;
            in_ready <= in_ready_d;
            underrun <= underrun_d;
        end
    end

endmodule

// File: tb/tb_pcm_sched.sv
// Bench for pcm_sched: directed timing table, corner sequences, and a random run against a queue model.
module tb_pcm_sched;

    localparam int DEPTH      = 8;
    localparam int PRIME_LVL  = 4;
    localparam int LOAD_PHASE = 1016;
    localparam int UR_LIMIT   = 16;

    logic        pclk        = 1'b0;
    logic        reset_n     = 1'b0;
    logic        enable      = 1'b0;
    logic        in_valid    = 1'b0;
    logic        ur_clr      = 1'b0;
    logic        sdm_started = 1'b0;
    logic [31:0] in_left     = '0;
    logic [31:0] in_right    = '0;
    logic        in_ready;
    logic        start;
    logic        running;
    logic        underrun;
    logic [31:0] pcm_l;
    logic [31:0] pcm_r;
    logic [3:0]  fill;

    pcm_sched #(
        .DEPTH      (DEPTH),
        .PRIME_LVL  (PRIME_LVL),
        .LOAD_PHASE (LOAD_PHASE),
        .UR_LIMIT   (UR_LIMIT)
    ) dut (
        .pclk        (pclk),
        .reset_n     (reset_n),
        .enable      (enable),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_left     (in_left),
        .in_right    (in_right),
        .start       (start),
        .pcm_l       (pcm_l),
        .pcm_r       (pcm_r),
        .sdm_started (sdm_started),
        .running     (running),
        .underrun    (underrun),
        .ur_clr      (ur_clr),
        .fill        (fill)
    );

    always #5 pclk = ~pclk;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    // ---------------- reference model: a pair queue plus a play phase ----------------
    typedef enum {M_OFF, M_FILL, M_PLAY} mmode_t;
    mmode_t      m_mode;
    logic [63:0] m_q[$];
    int          m_phase;
    int          m_empties;
    logic        m_start, m_rdy, m_ur;
    logic [31:0] m_l, m_r;
    bit          mo_push, mo_set, mo_go, mo_empty;

    always @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            m_mode = M_OFF; m_q.delete(); m_phase = 1023; m_empties = 0;
            m_start = 0; m_rdy = 0; m_ur = 0; m_l = 0; m_r = 0;
        end else begin
            mo_push = in_valid && m_rdy;
            mo_set  = 0;
            if (!enable) begin
                m_mode = M_OFF; m_q.delete(); m_l = 0; m_r = 0;
                m_start = 0; m_phase = 1023; m_empties = 0;
            end else if (m_mode == M_OFF) begin
                m_mode = M_FILL;
            end else if (m_mode == M_FILL) begin
                mo_go = (m_q.size() >= PRIME_LVL);
                if (mo_push) m_q.push_back({in_left, in_right});
                if (mo_go) begin
                    {m_l, m_r} = m_q.pop_front();
                    m_start = 1; m_mode = M_PLAY; m_phase = 1023;
                end
            end else begin
                mo_empty = (m_q.size() == 0);
                if (mo_push) m_q.push_back({in_left, in_right});
                if (m_phase == LOAD_PHASE) begin
                    if (mo_empty) begin
                        m_l = 0; m_r = 0; mo_set = 1; m_empties++;
                    end else begin
                        {m_l, m_r} = m_q.pop_front(); m_empties = 0;
                    end
                end
                if (UR_LIMIT != 0 && m_empties == UR_LIMIT) begin
                    m_mode = M_FILL; m_start = 0; m_l = 0; m_r = 0;
                    m_phase = 1023; m_empties = 0;
                end else begin
                    m_phase = (m_phase + 1) % 1024;
                end
            end
            if (mo_set)      m_ur = 1;
            else if (ur_clr) m_ur = 0;
            m_rdy = (m_mode != M_OFF) && (m_q.size() < DEPTH);
        end
    end

    task automatic chk(string name, logic [95:0] got, logic [95:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, got, exp);
    endtask

    task automatic check_model();
        chk("model", {start, in_ready, running, underrun, fill, pcm_l, pcm_r},
            {m_start, m_rdy, (m_mode == M_PLAY) && sdm_started, m_ur, 4'(m_q.size()), m_l, m_r});
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
        cyc++;
        check_model();
    endtask

    task automatic push_pairs(int first, int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_left  = 32'(first + i);
            in_right = 32'(-(first + i));
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_start(string name, int exp_cyc);
        int lim;
        lim = cyc + 40;
        while (!start && cyc < lim) tick();
        chk(name, 96'(cyc), 96'(exp_cyc));
    endtask

    // ---------------- timing table for the first prime/run/underrun cycle ----------------
    typedef struct {
        int          off;
        logic        sdm;
        logic        st;
        logic        run;
        logic        ur;
        logic [3:0]  fl;
        logic [31:0] l;
        logic [31:0] r;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(int off, bit sdm, bit st, bit run, bit ur, int fl, int l);
        vec_t v;
        v.off = off; v.sdm = sdm; v.st = st; v.run = run; v.ur = ur;
        v.fl = 4'(fl); v.l = 32'(l); v.r = 32'(-l);
        return v;
    endfunction

    initial begin
        int c0;
        int t0;
        int dens;

        vecs.push_back(mk(0,     0, 1, 0, 0, 3, 1));
        vecs.push_back(mk(1000,  0, 1, 0, 0, 3, 1));
        vecs.push_back(mk(1001,  1, 1, 1, 0, 3, 1));
        vecs.push_back(mk(1017,  1, 1, 1, 0, 3, 1));
        vecs.push_back(mk(1018,  1, 1, 1, 0, 2, 2));
        vecs.push_back(mk(2041,  1, 1, 1, 0, 2, 2));
        vecs.push_back(mk(2042,  1, 1, 1, 0, 1, 3));
        vecs.push_back(mk(3066,  1, 1, 1, 0, 0, 4));
        vecs.push_back(mk(4089,  1, 1, 1, 0, 0, 4));
        vecs.push_back(mk(4090,  1, 1, 1, 1, 0, 0));
        vecs.push_back(mk(19449, 1, 1, 1, 1, 0, 0));
        vecs.push_back(mk(19450, 1, 0, 0, 1, 0, 0));

        // Reset state
        tick();
        tick();
        chk("reset", {start, in_ready, running, underrun, fill, pcm_l, pcm_r}, 72'd0);
        reset_n = 1'b1;
        tick();

        // Prime with (1,-1)..(4,-4), then play through underrun and re-prime
        enable = 1'b1;
        c0 = cyc;
        tick();
        chk("rdy_prime", 96'(in_ready), 96'(1));
        push_pairs(1, 4);
        wait_start("t_start", c0 + 6);
        t0 = cyc;
        foreach (vecs[i]) begin
            while (cyc < t0 + vecs[i].off) tick();
            sdm_started = vecs[i].sdm;
            #1;
            chk($sformatf("vec%0d", i), {start, running, underrun, fill, pcm_l, pcm_r},
                {vecs[i].st, vecs[i].run, vecs[i].ur, vecs[i].fl, vecs[i].l, vecs[i].r});
        end

        // Re-feed after re-prime: same start timing
        c0 = cyc;
        push_pairs(5, 4);
        wait_start("t_restart", c0 + 5);
        t0 = cyc;
        chk("restart_pcm", {pcm_l, pcm_r}, {32'd5, 32'hFFFF_FFFB});
        while (cyc < t0 + 1017) tick();
        chk("restart_hold", {pcm_l, pcm_r}, {32'd5, 32'hFFFF_FFFB});
        tick();
        chk("restart_load", {pcm_l, pcm_r}, {32'd6, 32'hFFFF_FFFA});

        // Continuous feed: saturation and one-cycle in_ready after each load
        in_valid = 1'b1;
        in_left  = 32'h1234_5678;
        in_right = 32'h8765_4321;
        repeat (12) tick();
        chk("sat", {fill, in_ready}, {4'd8, 1'b0});
        while (cyc < t0 + 2042) tick();
        chk("sat_pop", {fill, in_ready}, {4'd7, 1'b1});
        tick();
        chk("sat_refill", {fill, in_ready}, {4'd8, 1'b0});
        in_valid = 1'b0;

        // enable drop mid-period keeps the sticky flag; ur_clr alone clears it
        repeat (100) tick();
        enable = 1'b0;
        tick();
        chk("disable", {start, in_ready, fill, pcm_l, pcm_r, underrun}, {1'b0, 1'b0, 4'd0, 64'd0, 1'b1});
        ur_clr = 1'b1;
        tick();
        ur_clr = 1'b0;
        chk("ur_clr", 96'(underrun), 96'(0));

        // ur_clr on the same edge as an empty load: set wins
        enable = 1'b1;
        tick();
        c0 = cyc;
        push_pairs(9, 4);
        wait_start("t_start3", c0 + 5);
        t0 = cyc;
        while (cyc < t0 + 4089) tick();
        ur_clr = 1'b1;
        tick();
        ur_clr = 1'b0;
        chk("ur_set_wins", {underrun, pcm_l, pcm_r}, {1'b1, 64'd0});

        // Asynchronous reset mid-cycle while running with data in flight
        push_pairs(20, 3);
        while (cyc < t0 + 5114) tick();
        chk("pre_rst", {start, pcm_l}, {1'b1, 32'd20});
        #3;
        reset_n = 1'b0;
        #1;
        chk("async_rst", {start, in_ready, underrun, fill, pcm_l, pcm_r}, 70'd0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        // Random traffic against the model
        for (int blk = 0; blk < 10; blk++) begin
            case ($urandom_range(0, 3))
                0:       dens = 0;
                1:       dens = 1;
                2:       dens = 3;
                default: dens = 500;
            endcase
            for (int k = 0; k < 2048; k++) begin
                in_valid    = ($urandom_range(0, 999) < dens);
                in_left     = $urandom;
                in_right    = $urandom;
                ur_clr      = ($urandom_range(0, 199) == 0);
                sdm_started = ($urandom_range(0, 3) != 0);
                enable      = ($urandom_range(0, 4999) != 0);
                tick();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
